// File: rtl/fpga_trng_nibble_sched_pkg.sv
// +---------------------------------------------------------------------------+
// | fpga_trng_pkg : shared types and constants for the TRNG nibble scheduler  |
// | Revision      : 1.0                                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

package fpga_trng_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    STARVE = 2'd2
  } trng_sched_state_e;

  localparam int unsigned NIBBLES_PER_WORD = 8;
  localparam int unsigned MIN_DIVIDER      = 2;

  // Terminal count of the interval counter; dividers below the floor are clamped.
  function automatic logic [31:0] expiry_count(input logic [31:0] divider);
    return (divider < MIN_DIVIDER) ? 32'(MIN_DIVIDER - 1) : (divider - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpga_trng_nibble_sched_if.sv
// +---------------------------------------------------------------------------+
// | fpga_trng_nibble_sched_if : config, host push port and Caliptra TRNG side |
// | Revision                  : 1.0                                           |
// +---------------------------------------------------------------------------+
`default_nettype none

interface fpga_trng_nibble_sched_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             cfg_enable;
  logic [DIV_W-1:0] cfg_divider;
  logic             etrng_req;
  logic             wr_valid;
  logic [31:0]      wr_data;
  logic             wr_ready;
  logic [3:0]       itrng_data;
  logic             itrng_valid;
  logic [LVL_W-1:0] fifo_level;
  logic             underflow;
  logic             underflow_clr;

  modport master (
    output cfg_enable, cfg_divider, etrng_req, wr_valid, wr_data, underflow_clr,
    input  wr_ready, itrng_data, itrng_valid, fifo_level, underflow
  );

  modport slave (
    input  cfg_enable, cfg_divider, etrng_req, wr_valid, wr_data, underflow_clr,
    output wr_ready, itrng_data, itrng_valid, fifo_level, underflow
  );

endinterface

`default_nettype wire

// File: rtl/fpga_trng_nibble_sched_fifo.sv
// +---------------------------------------------------------------------------+
// | fpga_trng_fifo : synchronous 32-bit word FIFO with full/empty/level       |
// | Revision       : 1.0                                                      |
// +---------------------------------------------------------------------------+
`default_nettype none

module fpga_trng_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [31:0]                   wdata_i,
  input  logic                          pop_i,
  output logic [31:0]                   rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full is judged on the registered level, so a same-cycle pop never frees a slot early.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/fpga_trng_nibble_sched.sv
// +---------------------------------------------------------------------------+
// | fpga_trng_nibble_sched : serializes host entropy words into paced nibbles |
// | for the Caliptra itrng inputs. Option: FPGA_TRNG_FIB_FALLBACK_EN.         |
// | Revision               : 1.0                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module fpga_trng_nibble_sched
  import fpga_trng_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                       core_clk,
  input  logic                       core_rst,
  fpga_trng_nibble_sched_if.slave    bus
);

  trng_sched_state_e state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [3:0]        nib_left_q, nib_left_d;
  logic [3:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              underflow_q, underflow_d;

  logic        go, expire, emit, fib_emit, set_underflow, load;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_rdata;
  logic [3:0]  fib_nib;

  assign go     = bus.cfg_enable && bus.etrng_req;
  assign expire = (32'(cnt_q) >= expiry_count(32'(bus.cfg_divider)));
  // Words are only pulled out of the FIFO while the scheduler is running.
  assign load   = (nib_left_q == 4'd0) && !fifo_empty && (state_q != IDLE);

  assign bus.wr_ready    = !fifo_full && !core_rst;
  assign bus.itrng_data  = data_q;
  assign bus.itrng_valid = valid_q;
  assign bus.underflow   = underflow_q;

  fpga_trng_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (core_clk),
    .rst_i   (core_rst),
    .push_i  (bus.wr_valid && bus.wr_ready),
    .wdata_i (bus.wr_data),
    .pop_i   (load),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (bus.fifo_level)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    emit          = 1'b0;
    fib_emit      = 1'b0;
    set_underflow = 1'b0;
    if (!go) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = COUNT;
          cnt_d   = '0;
        end
        COUNT: begin
          if (expire) begin
            cnt_d = '0;
            if (nib_left_q != 4'd0) begin
              emit = 1'b1;
            end else begin
              set_underflow = 1'b1;
`ifdef FPGA_TRNG_FIB_FALLBACK_EN
              fib_emit = 1'b1;
`else
              state_d = STARVE;
`endif
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
        STARVE: begin
          if (nib_left_q != 4'd0) begin
            emit    = 1'b1;
            state_d = COUNT;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    word_d      = word_q;
    nib_left_d  = nib_left_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    underflow_d = set_underflow | (underflow_q & ~bus.underflow_clr);
    if (emit) begin
      data_d     = word_q[3:0];
      valid_d    = 1'b1;
      word_d     = {4'h0, word_q[31:4]};
      nib_left_d = nib_left_q - 4'd1;
    end else if (fib_emit) begin
      data_d  = fib_nib;
      valid_d = 1'b1;
    end
    if (load) begin
      word_d     = fifo_rdata;
      nib_left_d = 4'(NIBBLES_PER_WORD);
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      nib_left_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      nib_left_q  <= nib_left_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FPGA_TRNG_FIB_FALLBACK_EN
  logic [3:0] fib_a_q, fib_b_q;

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      fib_a_q <= 4'd1;
      fib_b_q <= 4'd1;
    end else begin
      fib_a_q <= fib_b_q;
      fib_b_q <= fib_a_q + fib_b_q;
    end
  end

  assign fib_nib = fib_b_q;
`else
  assign fib_nib = 4'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpga_trng_nibble_sched.sv
// +---------------------------------------------------------------------------+
// | tb_fpga_trng_nibble_sched : directed vector table plus randomized run     |
// | against a queue-based reference model. Revision 1.0                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_fpga_trng_nibble_sched;
  localparam int DEPTH = 4;
  localparam int DIV_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpga_trng_nibble_sched_if #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) bus ();

  fpga_trng_nibble_sched #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .core_clk (clk),
    .core_rst (rst),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO as a queue, scheduler mode as small integers.
  localparam int M_IDLE = 0, M_COUNT = 1, M_STARVE = 2;
  int          m_mode, m_cnt, m_nib, m_fa, m_fb;
  logic [31:0] m_queue [$];
  logic [31:0] m_word;
  logic [3:0]  m_dat;
  logic        m_vld, m_und;

  task automatic model_step();
    int eff;
    bit go, push, load, emit, fib;
    int nf;
    if (rst) begin
      m_queue.delete();
      m_mode = M_IDLE; m_cnt = 0; m_nib = 0; m_word = '0;
      m_dat = '0; m_vld = 1'b0; m_und = 1'b0; m_fa = 1; m_fb = 1;
      return;
    end
    eff  = (int'(bus.cfg_divider) < 2) ? 2 : int'(bus.cfg_divider);
    go   = bus.cfg_enable && bus.etrng_req;
    push = bus.wr_valid && (m_queue.size() < DEPTH);
    load = (m_nib == 0) && (m_queue.size() > 0) && (m_mode != M_IDLE);
    emit = 0; fib = 0; m_vld = 1'b0;
    if (bus.underflow_clr) m_und = 1'b0;
    if (!go) begin
      m_mode = M_IDLE; m_cnt = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_COUNT; m_cnt = 0;
    end else if (m_mode == M_COUNT) begin
      if (m_cnt >= eff - 1) begin
        m_cnt = 0;
        if (m_nib > 0) emit = 1;
        else begin
          m_und = 1'b1;
`ifdef FPGA_TRNG_FIB_FALLBACK_EN
          fib = 1;
`else
          m_mode = M_STARVE;
`endif
        end
      end else m_cnt++;
    end else if (m_nib > 0) begin
      emit = 1; m_mode = M_COUNT; m_cnt = 0;
    end
    if (emit) begin
      m_vld = 1'b1; m_dat = m_word[3:0]; m_word = m_word >> 4; m_nib--;
    end
    if (fib) begin
      m_vld = 1'b1; m_dat = 4'(m_fb);
    end
    if (load) begin
      m_word = m_queue.pop_front(); m_nib = 8;
    end
    if (push) m_queue.push_back(bus.wr_data);
    nf = (m_fa + m_fb) % 16; m_fa = m_fb; m_fb = nf;
  endtask

  task automatic check_model();
    logic exp_rdy;
    exp_rdy = !rst && (m_queue.size() < DEPTH);
    n_tests++;
    if (bus.itrng_valid !== m_vld || bus.itrng_data !== m_dat || bus.underflow !== m_und ||
        bus.fifo_level !== 3'(m_queue.size()) || bus.wr_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL model t=%0t: got vld=%b dat=%h und=%b lvl=%0d rdy=%b, want vld=%b dat=%h und=%b lvl=%0d rdy=%b",
               $time, bus.itrng_valid, bus.itrng_data, bus.underflow, bus.fifo_level, bus.wr_ready,
               m_vld, m_dat, m_und, m_queue.size(), exp_rdy);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input logic r, input logic en, input logic req, input logic [15:0] div,
                       input logic wv, input logic [31:0] wd, input logic clr);
    rst = r; bus.cfg_enable = en; bus.etrng_req = req; bus.cfg_divider = div;
    bus.wr_valid = wv; bus.wr_data = wd; bus.underflow_clr = clr;
  endtask

  typedef struct {
    logic        r, en, req;
    logic [15:0] div;
    logic        wv;
    logic [31:0] wd;
    logic        clr;
    int          n;
    logic        e_vld;
    logic [3:0]  e_dat;
    logic        e_und;
    int          e_lvl;
    logic        e_rdy;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(logic r, logic en, logic req, logic [15:0] div, logic wv,
                              logic [31:0] wd, logic clr, int n, logic vld, logic [3:0] dat,
                              logic und, int lvl, logic rdy);
    tbl.push_back('{r, en, req, div, wv, wd, clr, n, vld, dat, und, lvl, rdy});
  endfunction

  initial begin
    logic en_r, req_r, wv_r, clr_r, rst_r;
    logic [15:0] div_r;
    int push_mod;

    //   r en rq div  wv wd             clr n   vld dat  und lvl rdy
    add(1, 0, 0, 4,  0, 32'h0,         0, 1,  0, 4'h0, 0, 0, 0);  // reset
    add(0, 1, 1, 4,  1, 32'h8765_4321, 0, 1,  0, 4'h0, 0, 1, 1);  // push
    add(0, 1, 1, 4,  0, 32'h0,         0, 1,  0, 4'h0, 0, 0, 1);  // load
    add(0, 1, 1, 4,  0, 32'h0,         0, 3,  1, 4'h1, 0, 0, 1);
    add(0, 1, 1, 4,  0, 32'h0,         0, 4,  1, 4'h2, 0, 0, 1);
    add(0, 1, 1, 4,  0, 32'h0,         0, 3,  0, 4'h2, 0, 0, 1);  // data holds
    add(0, 1, 1, 4,  0, 32'h0,         0, 1,  1, 4'h3, 0, 0, 1);
    add(0, 1, 1, 4,  0, 32'h0,         0, 20, 1, 4'h8, 0, 0, 1);
    add(0, 1, 1, 4,  0, 32'h0,         0, 4,  0, 4'h8, 1, 0, 1);  // starve
    add(0, 1, 1, 4,  0, 32'h0,         1, 1,  0, 4'h8, 0, 0, 1);  // clear
    add(0, 1, 1, 4,  1, 32'h0000_00A5, 0, 1,  0, 4'h8, 0, 1, 1);
    add(0, 1, 1, 4,  0, 32'h0,         0, 1,  0, 4'h8, 0, 0, 1);
    add(0, 1, 1, 4,  0, 32'h0,         0, 1,  1, 4'h5, 0, 0, 1);  // push+2
    add(1, 1, 0, 4,  0, 32'h0,         0, 1,  0, 4'h0, 0, 0, 0);
    add(0, 1, 0, 4,  1, 32'hCAFE_F00D, 0, 4,  0, 4'h0, 0, 4, 0);  // fill
    add(0, 1, 0, 4,  1, 32'hCAFE_F00D, 0, 2,  0, 4'h0, 0, 4, 0);  // 5th held
    add(0, 1, 1, 4,  1, 32'hCAFE_F00D, 0, 1,  0, 4'h0, 0, 4, 0);
    add(0, 1, 1, 4,  1, 32'hCAFE_F00D, 0, 1,  0, 4'h0, 0, 3, 1);  // pop, no push
    add(0, 1, 1, 4,  1, 32'hCAFE_F00D, 0, 1,  0, 4'h0, 0, 4, 0);  // 5th in
    add(0, 1, 1, 4,  0, 32'h0,         0, 2,  1, 4'hD, 0, 4, 0);
    add(1, 1, 1, 3,  0, 32'h0,         0, 1,  0, 4'h0, 0, 0, 0);
    add(0, 1, 1, 3,  1, 32'hFEDC_BA98, 0, 1,  0, 4'h0, 0, 1, 1);
    add(0, 1, 1, 3,  0, 32'h0,         0, 1,  0, 4'h0, 0, 0, 1);
    add(0, 1, 1, 3,  0, 32'h0,         0, 2,  1, 4'h8, 0, 0, 1);
    add(0, 1, 1, 3,  0, 32'h0,         0, 3,  1, 4'h9, 0, 0, 1);
    add(0, 1, 1, 3,  0, 32'h0,         0, 3,  1, 4'hA, 0, 0, 1);
    add(0, 1, 0, 3,  0, 32'h0,         0, 5,  0, 4'hA, 0, 0, 1);  // req drop
    add(0, 1, 1, 3,  0, 32'h0,         0, 1,  0, 4'hA, 0, 0, 1);
    add(0, 1, 1, 3,  0, 32'h0,         0, 2,  0, 4'hA, 0, 0, 1);
    add(0, 1, 1, 3,  0, 32'h0,         0, 1,  1, 4'hB, 0, 0, 1);  // resume
    add(0, 1, 1, 0,  0, 32'h0,         0, 1,  0, 4'hB, 0, 0, 1);
    add(0, 1, 1, 0,  0, 32'h0,         0, 1,  1, 4'hC, 0, 0, 1);  // div 0
    add(0, 1, 1, 1,  0, 32'h0,         0, 1,  0, 4'hC, 0, 0, 1);
    add(0, 1, 1, 1,  0, 32'h0,         0, 1,  1, 4'hD, 0, 0, 1);  // div 1
    add(0, 1, 1, 8,  0, 32'h0,         0, 5,  0, 4'hD, 0, 0, 1);
    add(0, 1, 1, 3,  0, 32'h0,         0, 1,  1, 4'hE, 0, 0, 1);  // shrink div
    add(1, 1, 1, 3,  0, 32'h0,         0, 1,  0, 4'h0, 0, 0, 0);  // reset mid-word
    add(0, 1, 1, 3,  0, 32'h0,         0, 12, 0, 4'h0, 1, 0, 1);  // no stale nibble

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].en, tbl[i].req, tbl[i].div, tbl[i].wv, tbl[i].wd, tbl[i].clr);
      repeat (tbl[i].n) tick();
`ifndef FPGA_TRNG_FIB_FALLBACK_EN
      n_tests++;
      if (bus.itrng_valid !== tbl[i].e_vld || bus.itrng_data !== tbl[i].e_dat ||
          bus.underflow !== tbl[i].e_und || bus.fifo_level !== 3'(tbl[i].e_lvl) ||
          bus.wr_ready !== tbl[i].e_rdy) begin
        n_fail++;
        $display("FAIL vec%0d: got vld=%b dat=%h und=%b lvl=%0d rdy=%b, want vld=%b dat=%h und=%b lvl=%0d rdy=%b",
                 i, bus.itrng_valid, bus.itrng_data, bus.underflow, bus.fifo_level, bus.wr_ready,
                 tbl[i].e_vld, tbl[i].e_dat, tbl[i].e_und, tbl[i].e_lvl, tbl[i].e_rdy);
      end
`endif
    end

    // Randomized run: busy host first, then a sparse host to exercise starvation.
    en_r = 1'b1; req_r = 1'b1; div_r = 16'd3;
    for (int c = 0; c < 6000; c++) begin
      push_mod = (c < 3000) ? 3 : 60;
      rst_r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) en_r  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) req_r = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 39) == 0) div_r = 16'($urandom_range(0, 6));
      wv_r  = ($urandom_range(0, push_mod - 1) == 0);
      clr_r = ($urandom_range(0, 15) == 0);
      drive(rst_r, en_r, req_r, div_r, wv_r, $urandom, clr_r);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpga_trng_nibble_sched.md
# fpga_trng_nibble_sched

FPGA-only entropy scheduler that drives the `itrng_data` / `itrng_valid` inputs of `caliptra_top` from host-supplied entropy.
- The host pushes 32-bit words over a valid/ready port; the block buffers them in a small FIFO.
- It serializes each word into 4-bit nibbles, LSB nibble first, emitting one single-cycle `itrng_valid` pulse per programmable interval while `etrng_req` is high.
- It sits in the FPGA wrapper between the AXI register space and the Caliptra TRNG inputs, replacing free-running pseudo-random generation.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: entropy word FIFO depth; power of two, ≥2.
- `DIV_W`, default 16: width of the interval divider.

Ports:
- `core_clk`  in  1  core clock; the block's only clock.
- `core_rst`  in  1  reset, synchronous, active-high.
- `cfg_enable`  in  1  scheduler enable.
- `cfg_divider`  in  DIV_W  cycles between nibble pulses; values 0 and 1 act as 2.
- `etrng_req`  in  1  entropy request from `caliptra_top`.
- `wr_valid`  in  1  host entropy word valid.
- `wr_data`  in  32  host entropy word.
- `wr_ready`  out  1  FIFO can accept a word.
- `itrng_data`  out  4  nibble to Caliptra.
- `itrng_valid`  out  1  one-cycle nibble strobe.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO, excluding the shift register.
- `underflow`  out  1  sticky flag: an interval expired with no nibble available.
- `underflow_clr`  in  1  clears `underflow`.

## Operation
- Shift register `word_q` holds 32 bits; `nib_left` counts 0..8.
- **Load:** when `nib_left==0` and the FIFO is non-empty, pop one word into `word_q` and set `nib_left=8`.
  - Load takes one cycle.
  - There is no bypass from `wr_data` to `word_q`.
- **Emit:** drive `itrng_data=word_q[3:0]` and `itrng_valid=1` for one cycle, shift `word_q` right by 4, decrement `nib_left`.
- **State machine** (states live in the package):
  - IDLE: entered when `cfg_enable==0` or `etrng_req==0`. Interval counter is cleared. `word_q` and FIFO contents are retained.
  - COUNT: the counter increments each cycle. When it reaches the effective divider minus 1:
    - if `nib_left!=0`, emit and restart the counter at 0;
    - otherwise go to STARVE and set `underflow`.
  - STARVE: emit in the first cycle with `nib_left!=0`, then return to COUNT with the counter at 0.
  - IDLE→COUNT is taken when `cfg_enable && etrng_req`.
  - Any state→IDLE is taken when either `cfg_enable` or `etrng_req` drops. A pending pulse is suppressed.
- **FIFO:**
  - Push occurs on `wr_valid && wr_ready`.
  - `wr_ready = !full && !core_rst`.
  - Full is evaluated before a same-cycle pop, so no push is accepted at full even while popping.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **`underflow` flag:**
  - Set wins over `underflow_clr` in the same cycle.
  - Cleared only by `underflow_clr` or reset.
- A `cfg_divider` change takes effect at the next counter comparison. If the counter is already ≥ the new value, that counts as expiry.

## Timing
- Reset values:
  - `itrng_valid=0`, `itrng_data=0`, `underflow=0`, `fifo_level=0`;
  - `wr_ready=0` while `core_rst` is high, then 1;
  - state IDLE, `nib_left=0`, counter 0.
- `itrng_data` and `itrng_valid` are registered. `itrng_data` holds its last value between pulses.
- Push-to-use latency when the block starts empty: push accepted at cycle 0 → FIFO entry visible at cycle 1 → load at cycle 1 → `word_q` valid at cycle 2.
  - The earliest pulse is at cycle 2 if in STARVE.
  - Otherwise the pulse comes at the next interval expiry.
- In steady state, pulses are exactly `max(cfg_divider,2)` cycles apart.
- Reset mid-operation clears FIFO, `word_q` and flags in the same cycle. No pulse is emitted in the reset cycle.

## Configuration
- `FPGA_TRNG_FIB_FALLBACK_EN` defined:
  - Adds a 4-bit Fibonacci generator (`a`, `b` reset to 1, updating each cycle as `b<=a+b`, `a<=b` modulo 16).
  - In COUNT, an expiry with `nib_left==0` emits `fib_b` instead of entering STARVE.
  - `underflow` is still set.
  - STARVE is unreachable.
- `FPGA_TRNG_FIB_FALLBACK_EN` undefined: no generator logic; starvation behaves as described in Operation.

## Structure
- Package `fpga_trng_pkg`:
  - state enum `trng_sched_state_e` (IDLE, COUNT, STARVE);
  - `NIBBLES_PER_WORD=8`;
  - `MIN_DIVIDER=2`.
- Sub-module `fpga_trng_fifo`: synchronous word FIFO with full, empty and level outputs, parameterized by `FIFO_DEPTH`.
- Top-level `fpga_trng_nibble_sched` contains the FSM, interval counter, shift register and the optional generator.

## Test plan
- **Basic serialization:** `cfg_divider=4`, `etrng_req=1`, push `32'h8765_4321` → pulses 4 cycles apart carrying 1,2,3,4,5,6,7,8; then `underflow=1`.
- **Back-pressure:** push 5 words with `FIFO_DEPTH=4` and `etrng_req=0` → the 5th is held with `wr_ready=0` and `fifo_level=4`. Raising `etrng_req` drains the FIFO; the 5th is accepted after the first pop.
- **Request drop:** drop `etrng_req` mid-word after 3 nibbles of `32'hFEDC_BA98`, then re-raise → resumes with nibble B after a full interval.
- **Divider floor:** `cfg_divider=0` and `1` → pulses exactly 2 cycles apart.
- **Starvation:**
  - Without the macro: empty FIFO → no pulse and `underflow=1`. A later push yields a pulse 2 cycles after the push.
  - With the macro: pulses carry 2,3,5,8,... per generator phase.
- **Reset mid-word:** assert `core_rst` for 1 cycle mid-word → all outputs return to reset values, `fifo_level=0`, and no stale nibbles are emitted afterwards.
